pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/pc_stack.sv | 66 ++++++
 rtl/pc_sequencer.sv | 114 +++++++++++
 tb/tb_pc_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared defaults and the next-PC source encoding for the PC sequencer.
package pc_seq_pkg;

   localparam int DEF_WIDTH       = 4;
   localparam int DEF_RST_VECTOR  = 5;
   localparam int DEF_STACK_DEPTH = 4;

   // Source chosen for the next program counter value.
   typedef enum logic [2:0] {
      NS_HOLD,
      NS_INC,
      NS_JUMP,
      NS_BRANCH,
      NS_CALL,
      NS_RET
   } ns_sel_e;

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO. The top entry is read combinationally so that a RET can
// load the PC on the same edge that pops it. Occupancy flags are registered.
module pc_stack
   import pc_seq_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(STACK_DEPTH);

   logic [WIDTH-1:0] mem_q [STACK_DEPTH];
   logic [PW:0]      cnt_q, cnt_d;
   logic [PW-1:0]    top_idx;
   logic             do_push, do_pop;
   logic             full_q, empty_q;

   // Guard against over/underflow even if the caller forgets to.
   assign do_push = push && !full_q;
   assign do_pop  = pop && !empty_q && !do_push;

   // Topmost valid slot; wraps to DEPTH-1 when the stack is full.
   assign top_idx  = cnt_q[PW-1:0] - PW'(1);
   assign data_out = mem_q[top_idx];

   // Occupancy count for the next edge.
   always_comb begin
      cnt_d = cnt_q;
      if (do_push)
         cnt_d = cnt_q + (PW+1)'(1);
      else if (do_pop)
         cnt_d = cnt_q - (PW+1)'(1);
   end

   // Storage write; contents are not cleared by reset.
   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[cnt_q[PW-1:0]] <= data_in;
   end

   // Occupancy count and registered flags derived from the new count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == (PW+1)'(STACK_DEPTH));
         empty_q <= (cnt_d == '0);
      end
   end

   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: increment, jump, conditional relative branch,
// and call/return through a small return-address stack.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int RST_VECTOR  = DEF_RST_VECTOR,
   parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             PL,
   input  logic             JB,
   input  logic             BC,
   input  logic             CALL,
   input  logic             RET,
   input  logic [WIDTH-1:0] OFFSET,
   input  logic [WIDTH-1:0] AData,
   output logic [WIDTH-1:0] PC,
   output logic             STACK_FULL,
   output logic             STACK_EMPTY,
   output logic             FAULT
);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pc_inc, pc_br, ret_addr;
   logic             fault_q, fault_d;
   logic             push, pop, stk_full, stk_empty, take_branch;
   ns_sel_e          sel;

   // All arithmetic wraps silently at WIDTH bits; OFFSET's two's-complement
   // encoding makes a plain modular add equal to a signed displacement.
   assign pc_inc      = pc_q + WIDTH'(1);
   assign pc_br       = pc_q + OFFSET;
   assign take_branch = BC ? AData[WIDTH-1] : (AData == '0);

   // Pick the next-PC source by priority and decide stack/fault side effects.
   always_comb begin
      sel     = NS_HOLD;
      push    = 1'b0;
      pop     = 1'b0;
      fault_d = fault_q;
      if (EN) begin
         if (RET) begin
            if (!stk_empty) begin
               sel = NS_RET;
               pop = 1'b1;
            end else begin
               sel     = NS_INC;
               fault_d = 1'b1;
            end
         end else if (CALL) begin
            if (!stk_full) begin
               sel  = NS_CALL;
               push = 1'b1;
            end else begin
               sel     = NS_INC;
               fault_d = 1'b1;
            end
         end else if (!PL) begin
            sel = NS_INC;
         end else if (JB) begin
            sel = NS_JUMP;
         end else begin
            sel = take_branch ? NS_BRANCH : NS_INC;
         end
      end
   end

   // Map the selected source to a PC value.
   always_comb begin
      pc_d = pc_q;
      case (sel)
         NS_INC:    pc_d = pc_inc;
         NS_JUMP:   pc_d = AData;
         NS_BRANCH: pc_d = pc_br;
         NS_CALL:   pc_d = AData;
         NS_RET:    pc_d = ret_addr;
         default:   pc_d = pc_q;
      endcase
   end

   // PC and sticky fault register.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         pc_q    <= WIDTH'(RST_VECTOR);
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         fault_q <= fault_d;
      end
   end

   pc_stack #(
      .WIDTH       (WIDTH),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk      (CLK),
      .rst_n    (RST_N),
      .push     (push),
      .pop      (pop),
      .data_in  (pc_inc),
      .data_out (ret_addr),
      .full     (stk_full),
      .empty    (stk_empty)
   );

   assign PC          = pc_q;
   assign FAULT       = fault_q;
   assign STACK_FULL  = stk_full;
   assign STACK_EMPTY = stk_empty;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a queue-based model.
module tb_pc_sequencer;

   logic       CLK = 1'b0;
   logic       RST_N, EN, PL, JB, BC, CALL, RET;
   logic [3:0] OFFSET, AData;
   logic [3:0] PC;
   logic       STACK_FULL, STACK_EMPTY, FAULT;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   int m_pc    = 0;
   bit m_fault = 1'b0;
   int m_stk[$];

   pc_sequencer #(
      .WIDTH       (4),
      .RST_VECTOR  (5),
      .STACK_DEPTH (4)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .EN          (EN),
      .PL          (PL),
      .JB          (JB),
      .BC          (BC),
      .CALL        (CALL),
      .RET         (RET),
      .OFFSET      (OFFSET),
      .AData       (AData),
      .PC          (PC),
      .STACK_FULL  (STACK_FULL),
      .STACK_EMPTY (STACK_EMPTY),
      .FAULT       (FAULT)
   );

   always #5 CLK = ~CLK;

   function automatic int wrap16(input int v);
      return ((v % 16) + 16) % 16;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the model, clock, and compare.
   task automatic cyc(input bit rn, input bit en, input bit pl, input bit jb, input bit bc,
                      input bit call, input bit ret, input int off, input int ad);
      int  soff;
      bit  take;
      RST_N = rn; EN = en; PL = pl; JB = jb; BC = bc; CALL = call; RET = ret;
      OFFSET = 4'(off); AData = 4'(ad);
      if (!rn) begin
         m_pc = 5;
         m_stk.delete();
         m_fault = 1'b0;
      end else if (en) begin
         if (ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = wrap16(m_pc + 1); m_fault = 1'b1; end
         end else if (call) begin
            if (m_stk.size() < 4) begin
               m_stk.push_back(wrap16(m_pc + 1));
               m_pc = ad;
            end else begin
               m_pc = wrap16(m_pc + 1);
               m_fault = 1'b1;
            end
         end else if (!pl) begin
            m_pc = wrap16(m_pc + 1);
         end else if (jb) begin
            m_pc = ad;
         end else begin
            soff = (off >= 8) ? off - 16 : off;
            take = bc ? (ad >= 8) : (ad == 0);
            m_pc = take ? wrap16(m_pc + soff) : wrap16(m_pc + 1);
         end
      end
      @(posedge CLK);
      #1;
      chk("pc",    16'(PC),          16'(m_pc));
      chk("full",  16'(STACK_FULL),  16'(m_stk.size() == 4));
      chk("empty", 16'(STACK_EMPTY), 16'(m_stk.size() == 0));
      chk("fault", 16'(FAULT),       16'(m_fault));
      $display("cyc rst_n=%0b en=%0b pl=%0b jb=%0b bc=%0b call=%0b ret=%0b off=%0d ad=%0d -> pc=%0d full=%0b empty=%0b fault=%0b",
               rn, en, pl, jb, bc, call, ret, off, ad, PC, STACK_FULL, STACK_EMPTY, FAULT);
   endtask

   initial begin
      //        rn en pl jb bc ca re off ad
      // Reset with EN low and noise on other inputs, then plain increments.
      cyc(0, 0, 1, 1, 0, 1, 0, 7, 3);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      // Wrap from 15 to 0, then a backward branch on zero from 2 to 0.
      cyc(1, 1, 1, 1, 0, 0, 0, 0, 14);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 1, 0, 0, 0, 0, 2);
      cyc(1, 1, 1, 0, 0, 0, 0, 14, 0);
      // Branch-on-negative taken/not taken, branch-on-zero not taken.
      cyc(1, 1, 1, 1, 0, 0, 0, 0, 5);
      cyc(1, 1, 1, 0, 1, 0, 0, 3, 8);
      cyc(1, 1, 1, 1, 0, 0, 0, 0, 5);
      cyc(1, 1, 1, 0, 1, 0, 0, 3, 7);
      cyc(1, 1, 1, 1, 0, 0, 0, 0, 5);
      cyc(1, 1, 1, 0, 0, 0, 0, 3, 1);
      // Call and return.
      cyc(1, 1, 1, 1, 0, 0, 0, 0, 5);
      cyc(1, 1, 1, 0, 0, 1, 0, 0, 10);
      cyc(1, 1, 1, 0, 0, 0, 1, 0, 0);
      // Return on empty stack after reset.
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 0, 0, 0, 1, 0, 0);
      // Five calls from empty; the fifth overflows. Stall during a call.
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 0, 0, 1, 0, 0, 1);
      cyc(1, 1, 1, 0, 0, 1, 0, 0, 2);
      cyc(1, 0, 1, 0, 0, 1, 0, 0, 9);
      cyc(1, 1, 1, 0, 0, 1, 0, 0, 3);
      cyc(1, 1, 1, 0, 0, 1, 0, 0, 4);
      cyc(1, 1, 1, 0, 0, 1, 0, 0, 12);
      cyc(1, 0, 1, 0, 0, 0, 1, 0, 0);
      // Reset with a full stack.
      cyc(0, 1, 1, 0, 0, 1, 1, 0, 0);
      // CALL and RET together with one entry stacked.
      cyc(1, 1, 1, 0, 0, 1, 0, 0, 10);
      cyc(1, 1, 1, 0, 0, 1, 1, 0, 13);
      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         bit rn, en, pl, jb, bc, ca, re;
         int off, ad;
         rn  = ($urandom_range(0, 49) != 0);
         en  = ($urandom_range(0, 7) != 0);
         pl  = ($urandom_range(0, 3) != 0);
         jb  = ($urandom_range(0, 2) == 0);
         bc  = 1'($urandom_range(0, 1));
         ca  = ($urandom_range(0, 3) == 0);
         re  = ($urandom_range(0, 4) == 0);
         off = $urandom_range(0, 15);
         ad  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
         cyc(rn, en, pl, jb, bc, ca, re, off, ad);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
